// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide, then a sign-fix cycle.
module mips_muldiv_unit #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [Width-1:0] src_a,
    input  logic [Width-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [Width-1:0] wd,
    output logic [Width-1:0] hi,
    output logic [Width-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (Width > 1) ? $clog2(Width) : 1;
    localparam int unsigned PW = 2 * Width;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [1:0]       op_q, op_next;
    logic [Width-1:0] mag_a, mag_a_next;
    logic [Width-1:0] mag_b, mag_b_next;
    logic             neg_a, neg_a_next;
    logic             neg_b, neg_b_next;
    logic [PW-1:0]    acc, acc_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [Width-1:0] hi_next, lo_next;
    logic             busy_next, done_next;

    logic             start_signed;
    logic [Width-1:0] start_mag_a, start_mag_b;
    logic [Width:0]   mul_sum;
    logic [Width:0]   div_trial, div_diff;
    logic             div_ge;
    logic [Width-1:0] div_rem;
    logic [PW-1:0]    prod_fix;
    logic [Width-1:0] quot, rem, raw_a;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= 2'd0;
            mag_a <= '0;
            mag_b <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            op_q  <= op_next;
            mag_a <= mag_a_next;
            mag_b <= mag_b_next;
            neg_a <= neg_a_next;
            neg_b <= neg_b_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            hi    <= hi_next;
            lo    <= lo_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // Next-state, iteration step and result formatting
    always_comb begin
        state_next = state;
        op_next    = op_q;
        mag_a_next = mag_a;
        mag_b_next = mag_b;
        neg_a_next = neg_a;
        neg_b_next = neg_b;
        acc_next   = acc;
        cnt_next   = cnt;
        hi_next    = hi;
        lo_next    = lo;
        done_next  = 1'b0;

        start_signed = ~op[0];
        start_mag_a  = (start_signed && src_a[Width-1]) ? (Width'(0) - src_a) : src_a;
        start_mag_b  = (start_signed && src_b[Width-1]) ? (Width'(0) - src_b) : src_b;

        mul_sum   = {1'b0, acc[PW-1:Width]} + (acc[0] ? {1'b0, mag_a} : (Width+1)'(0));
        div_trial = acc[PW-1:Width-1];
        div_diff  = div_trial - {1'b0, mag_b};
        div_ge    = ~div_diff[Width];
        div_rem   = div_ge ? div_diff[Width-1:0] : div_trial[Width-1:0];

        quot     = acc[Width-1:0];
        rem      = acc[PW-1:Width];
        prod_fix = (neg_a ^ neg_b) ? (PW'(0) - acc) : acc;
        raw_a    = neg_a ? (Width'(0) - mag_a) : mag_a;

        unique case (state)
            IDLE: begin
                if (start) begin
                    op_next    = op;
                    neg_a_next = start_signed & src_a[Width-1];
                    neg_b_next = start_signed & src_b[Width-1];
                    mag_a_next = start_mag_a;
                    mag_b_next = start_mag_b;
                    acc_next   = {Width'(0), op[1] ? start_mag_a : start_mag_b};
                    cnt_next   = '0;
                    state_next = CALC;
                end else begin
                    if (mthi) hi_next = wd;
                    if (mtlo) lo_next = wd;
                end
            end
            CALC: begin
                if (op_q[1]) acc_next = {div_rem, acc[Width-2:0], div_ge};
                else         acc_next = {mul_sum, acc[Width-1:1]};
                if (cnt == CW'(Width - 1)) begin
                    cnt_next   = '0;
                    state_next = FIX;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            FIX: begin
                if (!op_q[1]) begin
                    {hi_next, lo_next} = prod_fix;
                end else if (mag_b == '0) begin
                    lo_next = '1;
                    hi_next = raw_a;
                end else begin
                    lo_next = (neg_a ^ neg_b) ? (Width'(0) - quot) : quot;
                    hi_next = neg_a ? (Width'(0) - rem) : rem;
                end
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_mips_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src_a = '0, src_b = '0, wd = '0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int failures = 0;

    mips_muldiv_unit #(.Width(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo), .wd(wd),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: MIPS HI/LO results from plain integer arithmetic
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      p;
        logic [63:0] up;
        int          sa, sb;
        sa = a;
        sb = b;
        case (o)
            2'd0: begin p = longint'(sa) * longint'(sb); {eh, el} = p; end
            2'd1: begin up = {32'd0, a} * {32'd0, b}; {eh, el} = up; end
            2'd2: begin
                if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin el = 32'h8000_0000; eh = 32'd0; end
                else begin el = sa / sb; eh = sa % sb; end
            end
            default: begin
                if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; end
                else begin el = a / b; eh = a % b; end
            end
        endcase
    endfunction

    // Issue one op at a negedge; junk=1 also pulses start/mthi/mtlo mid-operation
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit junk);
        logic [31:0] eh, el, h0, l0;
        int cyc, busy_cnt;
        bit held;
        model(o, a, b, eh, el);
        h0 = hi; l0 = lo;
        start = 1'b1; op = o; src_a = a; src_b = b;
        if (junk) begin mthi = 1'b1; mtlo = 1'b1; wd = $urandom; end
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        src_a = $urandom; src_b = $urandom; op = 2'($urandom);
        cyc = 0; busy_cnt = 0; held = 1'b1;
        while (!done && cyc < 60) begin
            if (busy) busy_cnt++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            start = junk && (cyc == 10);
            mtlo  = junk && (cyc == 5);
            mthi  = junk && (cyc == 6);
            wd    = $urandom;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check({tag, "_done_seen"}, 64'(done), 64'd1);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_hilo_held"}, 64'(held), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle_after"}, 64'(busy), 64'd0);
        check({tag, "_hi_hold"}, 64'(hi), 64'(eh));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dcnt, bcnt;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("divu_100_7", 2'd3, 32'd100, 32'd7, 1'b0);
        do_op("divu_zero", 2'd3, 32'd100, 32'd0, 1'b0);
        do_op("div_zero_neg", 2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
        do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("mult_junk", 2'd0, 32'd6, 32'd7, 1'b1);

        // Moves in IDLE
        mthi = 1'b1; wd = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo_kept", 64'(lo), 64'd42);
        mtlo = 1'b1; mthi = 1'b1; wd = 32'hCAFE_F00D;
        @(negedge clk);
        mtlo = 1'b0; mthi = 1'b0;
        check("mtboth_hi", 64'(hi), 64'hCAFE_F00D);
        check("mtboth_lo", 64'(lo), 64'hCAFE_F00D);

        for (int i = 0; i < 40; i++) begin
            do_op($sformatf("rnd%0d", i), 2'($urandom), pick(), pick(), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a DIV
        do_op("pre_rst", 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        start = 1'b1; op = 2'd2; src_a = 32'd1000; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0; bcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        check("arst_no_done", 64'(dcnt), 64'd0);
        check("arst_no_busy", 64'(bcnt), 64'd0);
        check("arst_lo_after", 64'(lo), 64'd0);

        do_op("post_rst", 2'd2, 32'hFFFF_FF9C, 32'd7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
